// File: rtl/pe_pkg.sv
// Shared types, layer constants and mode lookups for the row-stationary processing element.
package pe_pkg;

    typedef enum logic [1:0] {MODE1, MODE2, MODE3, MODE4} op_mode_t;
    typedef enum logic [1:0] {IDLE, LOAD_FILTER, CONV} op_stage_t;
    typedef enum logic [2:0] {S_IDLE, S_WAIT_IN, S_MAC, S_WAIT_OUT, S_DONE} pe_state_t;

    typedef struct packed {
        logic            valid;
        logic [4:0]      packet_idx;
        logic [3:0][7:0] data;
    } pe_in_packet_t;

    typedef struct packed {
        logic              valid;
        logic [1:0]        filter_idx;
        logic signed [11:0] psum;
    } psum_packet_t;

    localparam int L1_FILTER_SIZE = 11;
    localparam int L1_IFMAP_SIZE  = 227;
    localparam int L1_OFMAP_SIZE  = 55;
    localparam int L1_STRIDE      = 4;
    localparam int L2_FILTER_SIZE = 5;
    localparam int L2_IFMAP_SIZE  = 31;
    localparam int L2_OFMAP_SIZE  = 27;
    localparam int L3_FILTER_SIZE = 3;
    localparam int L3_IFMAP_SIZE  = 15;
    localparam int L3_OFMAP_SIZE  = 13;
    localparam int OTHER_STRIDE   = 1;

    function automatic logic [3:0] filter_size(op_mode_t m);
        case (m)
            MODE3:   return 4'(L2_FILTER_SIZE);
            MODE4:   return 4'(L3_FILTER_SIZE);
            default: return 4'(L1_FILTER_SIZE);
        endcase
    endfunction

    function automatic logic [2:0] stride_of(op_mode_t m);
        case (m)
            MODE3, MODE4: return 3'(OTHER_STRIDE);
            default:      return 3'(L1_STRIDE);
        endcase
    endfunction

    function automatic logic [5:0] ofmap_size(op_mode_t m);
        case (m)
            MODE3:   return 6'(L2_OFMAP_SIZE);
            MODE4:   return 6'(L3_OFMAP_SIZE);
            default: return 6'(L1_OFMAP_SIZE);
        endcase
    endfunction

endpackage

// File: rtl/pe_if.sv
// Bundle of the PE's control, packet and psum handshake signals; master drives, slave is the PE.
interface pe_if;
    import pe_pkg::*;

    op_mode_t      mode_in;
    logic          change_mode;
    pe_in_packet_t ifmap_packet;
    pe_in_packet_t filter_packet;
    op_stage_t     op_stage_in;
    psum_packet_t  psum_in;
    logic          psum_ack_in;
    logic          conv_continue;
    psum_packet_t  psum_out;
    logic          psum_ack_out;
    logic          conv_done;
    logic          error;
    logic          full;

    modport master (
        output mode_in, change_mode, ifmap_packet, filter_packet, op_stage_in,
               psum_in, psum_ack_in, conv_continue,
        input  psum_out, psum_ack_out, conv_done, error, full
    );

    modport slave (
        input  mode_in, change_mode, ifmap_packet, filter_packet, op_stage_in,
               psum_in, psum_ack_in, conv_continue,
        output psum_out, psum_ack_out, conv_done, error, full
    );

endinterface

// File: rtl/pe_ifmap_spad.sv
// 16-entry ifmap sliding window: 4-pixel pushes, pops of 1..4 pixels, random read relative to the oldest pixel.
module pe_ifmap_spad (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic [3:0][7:0] push_data,
    input  logic            pop,
    input  logic [2:0]      pop_cnt,
    input  logic [3:0]      rd_idx,
    output logic [7:0]      rd_data,
    output logic [4:0]      count,
    output logic            full
);
    logic [7:0] mem [16];
    logic [3:0] rd_ptr;
    logic [3:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                for (int i = 0; i < 4; i++) mem[wr_ptr + 4'(i)] <= push_data[i];
                wr_ptr <= wr_ptr + 4'd4;
            end
            if (pop) rd_ptr <= rd_ptr + {1'b0, pop_cnt};
            count <= count + (push ? 5'd4 : 5'd0) - (pop ? {2'b00, pop_cnt} : 5'd0);
        end
    end

    // Pointers wrap at 16, so the window read needs no explicit modulo.
    assign rd_data = mem[rd_ptr + rd_idx];
    assign full    = count > 5'd12;

endmodule

// File: rtl/pe.sv
// Processing element: stores four filter rows, slides an ifmap window and adds
// one 1-D convolution per filter onto each incoming partial sum.
module pe
    import pe_pkg::*;
#(
    parameter int ROW_IDX = 0,
    parameter int COL_IDX = 0
) (
    input logic clk,
    input logic rst,
    pe_if.slave bus
);
    op_mode_t           mode;
    pe_state_t          state;
    logic signed [7:0]  taps [4][11];
    logic [1:0]         cur_filt;
    logic [3:0]         mac_k;
    logic signed [21:0] acc;
    logic [5:0]         out_cnt;
    psum_packet_t       psum_out_q;
    logic               ack_out_q;
    logic               done_q;
    logic               err_q;

    logic [3:0]         fs;
    logic [2:0]         stride;
    logic [5:0]         ofm;
    logic               ifmap_hit;
    logic               push;
    logic               filter_hit;
    logic [1:0]         filt_sel;
    logic               start_mac;
    logic               last_tap;
    logic               pop;
    logic [7:0]         rd_data;
    logic [4:0]         count;
    logic               full;
    logic signed [16:0] prod;
    logic signed [21:0] acc_next;
    logic               unused_acc_msbs;

    assign fs       = filter_size(mode);
    assign stride   = stride_of(mode);
    assign ofm      = ofmap_size(mode);
    assign filt_sel = bus.filter_packet.packet_idx[4:3];

    assign ifmap_hit  = bus.op_stage_in == CONV && bus.ifmap_packet.valid
                        && bus.ifmap_packet.packet_idx == 5'(ROW_IDX + COL_IDX)
                        && state inside {S_WAIT_IN, S_MAC, S_WAIT_OUT};
    assign push       = ifmap_hit && !full;
    assign filter_hit = bus.op_stage_in == LOAD_FILTER && bus.filter_packet.valid
                        && bus.filter_packet.packet_idx[2:0] == 3'(ROW_IDX);
    assign start_mac  = state == S_WAIT_IN && count >= {1'b0, fs} && bus.psum_in.valid
                        && !psum_out_q.valid && !ack_out_q;
    assign last_tap   = mac_k == fs - 4'd1;
    assign pop        = state == S_MAC && last_tap && cur_filt == 2'd3;

    // Pixels are unsigned, so a zero sign bit keeps the product signed-correct.
    assign prod            = taps[cur_filt][mac_k] * $signed({1'b0, rd_data});
    assign acc_next        = acc + {{5{prod[16]}}, prod};
    assign unused_acc_msbs = ^acc_next[21:20];

    pe_ifmap_spad u_spad (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.change_mode || bus.conv_continue),
        .push      (push),
        .push_data (bus.ifmap_packet.data),
        .pop       (pop),
        .pop_cnt   (stride),
        .rd_idx    (mac_k),
        .rd_data   (rd_data),
        .count     (count),
        .full      (full)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.change_mode) begin
            mode       <= rst ? MODE1 : bus.mode_in;
            state      <= S_IDLE;
            cur_filt   <= '0;
            mac_k      <= '0;
            acc        <= '0;
            out_cnt    <= '0;
            psum_out_q <= '0;
            ack_out_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int f = 0; f < 4; f++)
                for (int t = 0; t < 11; t++) taps[f][t] <= '0;
        end else begin
            ack_out_q <= 1'b0;
            // Each filter word slides earlier words toward the high taps.
            if (filter_hit) begin
                for (int t = 10; t >= 4; t--) taps[filt_sel][t] <= taps[filt_sel][t-4];
                for (int t = 0; t < 4; t++) taps[filt_sel][t] <= bus.filter_packet.data[t];
            end
            if (ifmap_hit && full) err_q <= 1'b1;

            if (bus.conv_continue) begin
                state      <= S_WAIT_IN;
                mac_k      <= '0;
                out_cnt    <= '0;
                psum_out_q <= '0;
                done_q     <= 1'b0;
                err_q      <= 1'b0;
            end else begin
                case (state)
                    S_WAIT_IN: if (start_mac) begin
                        cur_filt  <= bus.psum_in.filter_idx;
                        acc       <= {{2{bus.psum_in.psum[11]}}, bus.psum_in.psum, 8'h00};
                        mac_k     <= '0;
                        ack_out_q <= 1'b1;
                        state     <= S_MAC;
                    end
                    S_MAC: begin
                        acc <= acc_next;
                        if (last_tap) begin
                            psum_out_q.valid      <= 1'b1;
                            psum_out_q.filter_idx <= cur_filt;
                            psum_out_q.psum       <= acc_next[19:8];
                            if (cur_filt == 2'd3) out_cnt <= out_cnt + 6'd1;
                            state <= S_WAIT_OUT;
                        end else begin
                            mac_k <= mac_k + 4'd1;
                        end
                    end
                    S_WAIT_OUT: if (bus.psum_ack_in) begin
                        psum_out_q.valid <= 1'b0;
                        if (cur_filt == 2'd3 && out_cnt == ofm) begin
                            done_q <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            state <= S_WAIT_IN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.psum_out     = psum_out_q;
    assign bus.psum_ack_out = ack_out_q;
    assign bus.conv_done    = done_q;
    assign bus.error        = err_q;
    assign bus.full         = full;

endmodule

// File: tb/tb_pe.sv
// Self-checking bench for pe: randomized ifmaps/filters/psums against a plain-arithmetic convolution model.
module tb_pe;
    import pe_pkg::*;

    localparam int ROW = 1;
    localparam int COL = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    pe_if bus ();

    pe #(.ROW_IDX(ROW), .COL_IDX(COL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int w   [4][11];
    int pix [256];
    int ps  [256];
    int got [256];
    int cfg_fs, cfg_stride, cfg_ofm, cfg_npix;

    // Output n is ofmap pixel n/4 of filter n%4, in the fixed-point scales of the datapath.
    function automatic int model(int n);
        int o   = n / 4;
        int f   = n % 4;
        int sum = ps[n] * 256;
        for (int k = 0; k < cfg_fs; k++) sum += w[f][k] * pix[o * cfg_stride + k];
        return (sum >>> 8) & 32'hFFF;
    endfunction

    function automatic int rand_wait(input bit long_stalls, input int long_len);
        if (long_stalls && $urandom_range(0, 15) == 0) return long_len;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic drive_idle();
        bus.mode_in       = MODE1;
        bus.change_mode   = 1'b0;
        bus.ifmap_packet  = '0;
        bus.filter_packet = '0;
        bus.op_stage_in   = IDLE;
        bus.psum_in       = '0;
        bus.psum_ack_in   = 1'b0;
        bus.conv_continue = 1'b0;
    endtask

    task automatic set_mode(input op_mode_t m);
        bus.mode_in     = m;
        bus.change_mode = 1'b1;
        @(negedge clk);
        bus.change_mode = 1'b0;
        case (m)
            MODE3:   begin cfg_fs = 5;  cfg_stride = 1; cfg_ofm = 27; cfg_npix = 32;  end
            MODE4:   begin cfg_fs = 3;  cfg_stride = 1; cfg_ofm = 13; cfg_npix = 16;  end
            default: begin cfg_fs = 11; cfg_stride = 4; cfg_ofm = 55; cfg_npix = 228; end
        endcase
    endtask

    task automatic randomize_data(input bit const_psum, input int psum_val);
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 11; k++) w[f][k] = int'($urandom_range(0, 255)) - 128;
        for (int i = 0; i < 256; i++) begin
            pix[i] = int'($urandom_range(0, 255));
            ps[i]  = const_psum ? psum_val : int'($urandom_range(0, 4095)) - 2048;
            got[i] = -1;
        end
    endtask

    // The last word sent lands in taps 3..0; earlier words end up four taps higher each.
    task automatic load_filters();
        int nw = (cfg_fs + 3) / 4;
        pe_in_packet_t pk;
        bus.op_stage_in = LOAD_FILTER;
        pk.valid      = 1'b1;
        pk.packet_idx = {2'd2, 3'(ROW ^ 1)};
        pk.data       = {4{8'h55}};
        bus.filter_packet = pk;
        @(negedge clk);
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < nw; j++) begin
                int base = (nw - 1 - j) * 4;
                pk.packet_idx = {2'(f), 3'(ROW)};
                for (int b = 0; b < 4; b++) pk.data[b] = (base + b < cfg_fs) ? 8'(w[f][base + b]) : 8'h00;
                bus.filter_packet = pk;
                @(negedge clk);
            end
        end
        bus.filter_packet = '0;
        bus.op_stage_in   = CONV;
    endtask

    task automatic start_conv();
        bus.op_stage_in   = CONV;
        bus.conv_continue = 1'b1;
        @(negedge clk);
        bus.conv_continue = 1'b0;
    endtask

    task automatic send_ifmap(input int p);
        pe_in_packet_t pk;
        pk.valid      = 1'b1;
        pk.packet_idx = 5'(ROW + COL);
        for (int b = 0; b < 4; b++) pk.data[b] = 8'(pix[4 * p + b]);
        bus.ifmap_packet = pk;
    endtask

    // Drives ifmap packets, psum_in and psum_ack_in with optional long stalls until conv_done.
    task automatic run_loop(input int first_pkt, input bit long_stalls);
        int pkt   = first_pkt;
        int snd   = 0;
        int rcv   = 0;
        int cyc   = 0;
        int gap   = 0;
        int pwait = 0;
        int await_ack = 0;
        int npkt  = cfg_npix / 4;
        int nout  = cfg_ofm * 4;
        int val;
        while (bus.conv_done !== 1'b1 && cyc < 20000) begin
            if (bus.psum_out.valid === 1'b1) begin
                val = {20'b0, bus.psum_out.psum};
                tests++;
                if (rcv >= nout || val !== model(rcv) || int'(bus.psum_out.filter_idx) !== rcv % 4) begin
                    fails++;
                    $display("[TB] FAIL psum_out[%0d]: got %0d f%0d, expected %0d f%0d",
                             rcv, val, bus.psum_out.filter_idx, model(rcv), rcv % 4);
                end
                got[rcv] = val;
                if (await_ack == 0) begin
                    bus.psum_ack_in = 1'b1;
                    rcv++;
                    await_ack = rand_wait(long_stalls, 100);
                end else begin
                    bus.psum_ack_in = 1'b0;
                    await_ack--;
                end
            end else begin
                bus.psum_ack_in = 1'b0;
            end

            if (bus.psum_ack_out === 1'b1) begin
                snd++;
                bus.psum_in = '0;
                pwait = rand_wait(long_stalls, 100);
            end else if (bus.psum_in.valid == 1'b0 && snd < nout) begin
                if (pwait == 0) begin
                    bus.psum_in.valid      = 1'b1;
                    bus.psum_in.filter_idx = 2'(snd % 4);
                    bus.psum_in.psum       = 12'(ps[snd]);
                end else begin
                    pwait--;
                end
            end

            bus.ifmap_packet = '0;
            if (pkt < npkt) begin
                if (gap > 0) gap--;
                else if (bus.full === 1'b0) begin
                    send_ifmap(pkt);
                    pkt++;
                    gap = rand_wait(long_stalls, 300);
                end
            end
            @(negedge clk);
            cyc++;
        end
        bus.psum_ack_in  = 1'b0;
        bus.psum_in      = '0;
        bus.ifmap_packet = '0;
        tests++;
        if (bus.conv_done !== 1'b1 || rcv != nout) begin
            fails++;
            $display("[TB] FAIL conv_done: done=%b after %0d acks in %0d cycles, expected 1 after %0d acks",
                     bus.conv_done, rcv, cyc, nout);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.psum_out !== '0)       begin fails++; $display("[TB] FAIL reset psum_out: got %h, expected 0", bus.psum_out); end
        tests++; if (bus.psum_ack_out !== 1'b0) begin fails++; $display("[TB] FAIL reset psum_ack_out: got %b, expected 0", bus.psum_ack_out); end
        tests++; if (bus.conv_done !== 1'b0)    begin fails++; $display("[TB] FAIL reset conv_done: got %b, expected 0", bus.conv_done); end
        tests++; if (bus.error !== 1'b0)        begin fails++; $display("[TB] FAIL reset error: got %b, expected 0", bus.error); end
        tests++; if (bus.full !== 1'b0)         begin fails++; $display("[TB] FAIL reset full: got %b, expected 0", bus.full); end
    endtask

    task automatic test_mode1_directed();
        int f2 [11] = '{64, 16, 64, 64, 64, 0, -64, -64, -64, -64, -64};
        set_mode(MODE1);
        randomize_data(1'b1, 0);
        for (int k = 0; k < 11; k++) begin
            w[0][k] = (k % 2 == 0) ? 64 : 0;
            w[1][k] = (k == 0 || k == 10) ? 64 : 0;
            w[2][k] = f2[k];
        end
        for (int i = 0; i < 256; i++) pix[i] = (i < 11) ? 128 : 32;
        load_filters();
        start_conv();
        run_loop(0, 1'b0);
        tests++; if (got[0] !== 192)  begin fails++; $display("[TB] FAIL mode1 f0 out0: got %0d, expected 192", got[0]); end
        tests++; if (got[4] !== 144)  begin fails++; $display("[TB] FAIL mode1 f0 out1: got %0d, expected 144", got[4]); end
        tests++; if (got[1] !== 64)   begin fails++; $display("[TB] FAIL mode1 f1 out0: got %0d, expected 64", got[1]); end
        tests++; if (got[2] !== 4072) begin fails++; $display("[TB] FAIL mode1 f2 out0: got %0d, expected 4072", got[2]); end
    endtask

    task automatic test_mode1_stalls();
        set_mode(MODE1);
        randomize_data(1'b0, 0);
        load_filters();
        start_conv();
        run_loop(0, 1'b1);
    endtask

    task automatic test_mode3_offset();
        set_mode(MODE3);
        randomize_data(1'b1, 100);
        load_filters();
        start_conv();
        run_loop(0, 1'b1);
        send_ifmap(0);
        @(negedge clk);
        bus.ifmap_packet = '0;
        @(negedge clk);
        tests++; if (bus.error !== 1'b0 || bus.conv_done !== 1'b1) begin
            fails++; $display("[TB] FAIL mode3 after done: error=%b done=%b, expected error=0 done=1", bus.error, bus.conv_done);
        end
    endtask

    task automatic test_mode4_error();
        set_mode(MODE4);
        randomize_data(1'b0, 0);
        load_filters();
        start_conv();
        for (int p = 0; p < 4; p++) begin send_ifmap(p); @(negedge clk); end
        bus.ifmap_packet = '0;
        tests++; if (bus.full !== 1'b1) begin fails++; $display("[TB] FAIL mode4 full: got %b, expected 1", bus.full); end
        bus.ifmap_packet.valid      = 1'b1;
        bus.ifmap_packet.packet_idx = 5'(ROW + COL);
        bus.ifmap_packet.data       = {4{8'hFF}};
        @(negedge clk);
        bus.ifmap_packet = '0;
        tests++; if (bus.error !== 1'b1) begin fails++; $display("[TB] FAIL mode4 error: got %b, expected 1", bus.error); end
        run_loop(4, 1'b0);
        start_conv();
        tests++; if (bus.error !== 1'b0 || bus.conv_done !== 1'b0) begin
            fails++; $display("[TB] FAIL mode4 restart: error=%b done=%b, expected 0 0", bus.error, bus.conv_done);
        end
    endtask

    task automatic test_reset_mid();
        int i = 0;
        set_mode(MODE1);
        randomize_data(1'b0, 0);
        load_filters();
        start_conv();
        for (int p = 0; p < 4; p++) begin send_ifmap(p); @(negedge clk); end
        bus.ifmap_packet       = '0;
        bus.psum_in.valid      = 1'b1;
        bus.psum_in.filter_idx = 2'd0;
        bus.psum_in.psum       = 12'(ps[0]);
        while (bus.psum_out.valid !== 1'b1 && i < 100) begin
            if (bus.psum_ack_out === 1'b1) bus.psum_in = '0;
            @(negedge clk);
            i++;
        end
        bus.psum_in = '0;
        tests++; if (bus.psum_out.valid !== 1'b1 || {20'b0, bus.psum_out.psum} !== model(0)) begin
            fails++; $display("[TB] FAIL midconv psum: valid=%b got %0d, expected 1 %0d", bus.psum_out.valid, bus.psum_out.psum, model(0));
        end
        tests++; if (bus.full !== 1'b1) begin fails++; $display("[TB] FAIL midconv full: got %b, expected 1", bus.full); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (bus.psum_out !== '0)       begin fails++; $display("[TB] FAIL rst psum_out: got %h, expected 0", bus.psum_out); end
        tests++; if (bus.psum_ack_out !== 1'b0) begin fails++; $display("[TB] FAIL rst psum_ack_out: got %b, expected 0", bus.psum_ack_out); end
        tests++; if (bus.full !== 1'b0)         begin fails++; $display("[TB] FAIL rst full: got %b, expected 0", bus.full); end
        tests++; if (bus.conv_done !== 1'b0 || bus.error !== 1'b0) begin
            fails++; $display("[TB] FAIL rst flags: done=%b error=%b, expected 0 0", bus.conv_done, bus.error);
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_mode1_directed();
        test_mode1_stalls();
        test_mode3_offset();
        test_mode4_error();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #5_000_000;
        fails++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
